resp_sig_collector: RTL and testbench
=====================================

RESP_SIG_COLLECTOR -- requirements
Module: resp_sig_collector

Interface
REQ-001 Parameter RESP_W, default 330: width of the DUT response word compacted each cycle.
REQ-002 Parameter SIG_W, fixed 32: signature width; value other than 32 SHALL be rejected at elaboration.
REQ-003 Parameter TIMEOUT, default 1024: maximum consecutive idle RUN cycles (no resp_valid) before abort.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a new collection run.
REQ-007 cycles_target  input  16  number of responses to absorb; sampled on accepted start.
REQ-008 expected_sig  input  32  golden signature; sampled on accepted start.
REQ-009 resp_valid  input  1  resp_flat carries a response this cycle.
REQ-010 resp_flat  input  RESP_W  DUT output word (out_flat).
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  high in DONE, held until the next accepted start or reset.
REQ-013 match  output  1  in DONE: signature equals expected_sig and no timeout; else 0.
REQ-014 timeout  output  1  in DONE: run was aborted by the idle watchdog.
REQ-015 sig  output  32  current MISR signature.
REQ-016 resp_cnt  output  16  responses absorbed in the current or last run.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on completion or timeout; no other transitions.
REQ-018 start SHALL be accepted only in IDLE or DONE; start in RUN is ignored with no effect.
REQ-019 Accepted start SHALL, at the same edge, load sig=0xFFFFFFFF, clear resp_cnt, idle counter, match and timeout, latch cycles_target and expected_sig, and enter RUN (busy=1 the following cycle).
REQ-020 Fold: resp_flat SHALL be zero-extended to ceil(RESP_W/32)*32 bits, and all 32-bit chunks XORed into F (11 chunks for RESP_W=330).
REQ-021 MISR step, on each RUN cycle with resp_valid=1: sig <= {sig[30:0],1'b0} ^ (sig[31] ? 0x04C11DB7 : 0) ^ F; resp_cnt increments by 1.
REQ-022 resp_valid outside RUN SHALL be ignored: no change to sig or resp_cnt.
REQ-023 Completion: at the edge absorbing response number cycles_target, the FSM SHALL enter DONE; no further response is absorbed.
REQ-024 cycles_target=0 SHALL pass through RUN for exactly one cycle, absorb nothing, then enter DONE with sig=0xFFFFFFFF.
REQ-025 Idle counter SHALL clear on each absorbed response and increment on each RUN cycle without resp_valid; on reaching TIMEOUT, the FSM SHALL enter DONE with timeout=1 and match=0.
REQ-026 match SHALL be registered on entry to DONE as (final sig == latched expected_sig) && !timeout, and held stable throughout DONE.
REQ-027 resp_cnt SHALL saturate at 0xFFFF and never wrap.
REQ-028 Outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, match=0, timeout=0, sig=0xFFFFFFFF and resp_cnt=0.
REQ-030 Reset SHALL take priority over start and resp_valid in the same cycle.
REQ-031 Reset asserted in RUN SHALL abort the run without entering DONE.

Verification
REQ-032 Start with cycles_target=1, then one all-zero response -> DONE, sig=0xFB3EE249, resp_cnt=1.
REQ-033 Start with cycles_target=1, expected_sig=0xFB3EE248, then one response with only resp_flat[0]=1 -> sig=0xFB3EE248, match=1.
REQ-034 Start with cycles_target=0 -> busy high for 1 cycle, then done=1 and sig=0xFFFFFFFF; match=1 when expected_sig=0xFFFFFFFF.
REQ-035 TIMEOUT=4, start with cycles_target=3, one response, then resp_valid low -> DONE after 4 idle cycles, timeout=1, match=0, resp_cnt=1.
REQ-036 Start pulsed mid-RUN, and resp_valid driven in IDLE -> both ignored; sig and resp_cnt equal those of the reference model run.
REQ-037 rst_n low for 1 cycle mid-RUN with cycles_target=100 -> IDLE next cycle, done=0, sig=0xFFFFFFFF, resp_cnt=0; a later start runs cleanly.

Source files
------------

// File: rtl/resp_sig_collector.sv
// resp_sig_collector
//   Compacts a stream of wide DUT response words into a 32-bit MISR
//   signature. It then compares that signature against a golden value.
//   A run begins on start. It ends when cycles_target responses have been
//   absorbed, or when the idle watchdog sees TIMEOUT consecutive RUN cycles
//   with no response.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   start          one-cycle request for a new run (accepted in IDLE/DONE)
//   cycles_target  number of responses to absorb (latched on start)
//   expected_sig   golden signature (latched on start)
//   resp_valid     resp_flat carries a response this cycle
//   resp_flat      response word, RESP_W bits
//   busy           high while a run is in progress
//   done           high once a run has finished, until the next start
//   match          in DONE: signature equals golden and no timeout
//   timeout        in DONE: run was aborted by the idle watchdog
//   sig            current signature
//   resp_cnt       responses absorbed in the current or last run
module resp_sig_collector #(
  parameter int RESP_W  = 330,
  parameter int SIG_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       cycles_target,
  input  logic [SIG_W-1:0]  expected_sig,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_flat,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              timeout,
  output logic [SIG_W-1:0]  sig,
  output logic [15:0]       resp_cnt
);

  localparam int NCHUNK = (RESP_W + 31) / 32;
  localparam int PAD_W  = NCHUNK * 32;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

  // The MISR polynomial and fold are defined only for a 32-bit signature.
  generate
    if (SIG_W != 32) begin : g_bad_sig_w
      $error("resp_sig_collector: SIG_W must be 32");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("resp_sig_collector: TIMEOUT must be at least 1");
    end
  endgenerate

  // Fold the response word into one 32-bit word.
  // First zero-extend it to a whole number of 32-bit chunks.
  // Then XOR all the chunks together.
  logic [PAD_W-1:0] resp_pad;
  logic [31:0]      chunk [NCHUNK];
  logic [31:0]      fold;

  always_comb begin
    resp_pad              = '0;
    resp_pad[RESP_W-1:0]  = resp_flat;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk[gi] = resp_pad[gi*32 +: 32];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ chunk[i];
    end
  end

  // State
  logic [1:0]        state_reg,   state_next;
  logic [31:0]       sig_reg,     sig_next;
  logic [15:0]       cnt_reg,     cnt_next;
  logic [IDLE_W-1:0] idle_reg,    idle_next;
  logic [15:0]       target_reg,  target_next;
  logic [31:0]       exp_reg,     exp_next;
  logic              match_reg,   match_next;
  logic              timeout_reg, timeout_next;
  logic              busy_reg,    busy_next;
  logic              done_reg,    done_next;

  logic [31:0]       misr_step;
  logic [15:0]       cnt_sat;
  logic [IDLE_W-1:0] idle_inc;

  assign misr_step = {sig_reg[30:0], 1'b0} ^ (sig_reg[31] ? POLY : 32'h0) ^ fold;
  assign cnt_sat   = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
  assign idle_inc  = idle_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    sig_next     = sig_reg;
    cnt_next     = cnt_reg;
    idle_next    = idle_reg;
    target_next  = target_reg;
    exp_next     = exp_reg;
    match_next   = match_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next   = ST_RUN;
          sig_next     = SIG_SEED;
          cnt_next     = '0;
          idle_next    = '0;
          target_next  = cycles_target;
          exp_next     = expected_sig;
          match_next   = 1'b0;
          timeout_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (target_reg == 16'd0) begin
          // An empty run spends exactly one cycle in RUN and absorbs nothing.
          state_next = ST_DONE;
          match_next = (sig_reg == exp_reg);
        end else if (resp_valid) begin
          sig_next  = misr_step;
          cnt_next  = cnt_sat;
          idle_next = '0;
          if (cnt_sat == target_reg) begin
            state_next = ST_DONE;
            match_next = (misr_step == exp_reg);
          end
        end else begin
          idle_next = idle_inc;
          if (idle_inc == IDLE_W'(TIMEOUT)) begin
            state_next   = ST_DONE;
            timeout_next = 1'b1;
            match_next   = 1'b0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state.
  // This keeps busy and done aligned with state_reg without a decode on the outputs.
  assign busy_next = (state_next == ST_RUN);
  assign done_next = (state_next == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      sig_reg     <= SIG_SEED;
      cnt_reg     <= '0;
      idle_reg    <= '0;
      target_reg  <= '0;
      exp_reg     <= '0;
      match_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sig_reg     <= sig_next;
      cnt_reg     <= cnt_next;
      idle_reg    <= idle_next;
      target_reg  <= target_next;
      exp_reg     <= exp_next;
      match_reg   <= match_next;
      timeout_reg <= timeout_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign match    = match_reg;
  assign timeout  = timeout_reg;
  assign sig      = sig_reg;
  assign resp_cnt = cnt_reg;

endmodule

// File: tb/tb_resp_sig_collector.sv
module tb_resp_sig_collector;

  localparam int RESP_W = 330;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [15:0]       cycles_target;
  logic [31:0]       expected_sig;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_flat;
  logic              busy, done, match, timeout;
  logic [31:0]       sig;
  logic [15:0]       resp_cnt;

  int checks = 0;
  int errors = 0;

  resp_sig_collector #(.RESP_W(RESP_W), .SIG_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cycles_target(cycles_target),
    .expected_sig(expected_sig), .resp_valid(resp_valid), .resp_flat(resp_flat),
    .busy(busy), .done(done), .match(match), .timeout(timeout),
    .sig(sig), .resp_cnt(resp_cnt)
  );

  always #5 clk = ~clk;

  // Reference MISR step: fold 11 zero-extended chunks, then CRC-style shift.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [RESP_W-1:0] r);
    logic [351:0] p;
    logic [31:0]  f;
    p = '0;
    p[RESP_W-1:0] = r;
    f = '0;
    for (int i = 0; i < 11; i++) f = f ^ p[i*32 +: 32];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic begin_run(input logic [15:0] tgt, input logic [31:0] gold);
    start = 1'b1; cycles_target = tgt; expected_sig = gold;
    tick();
    start = 1'b0;
  endtask

  task automatic give(input logic [RESP_W-1:0] r);
    resp_valid = 1'b1; resp_flat = r;
    tick();
    resp_valid = 1'b0;
  endtask

  logic [RESP_W-1:0] r1, r2, r3, r4, rb;
  logic [31:0]       model;

  initial begin
    rst_n = 1'b0; start = 1'b0; cycles_target = '0; expected_sig = '0;
    resp_valid = 1'b0; resp_flat = '0;
    r1 = {10{33'h1_2345_6789}};
    r2 = {RESP_W{1'b1}};
    r3 = {11{30'h2AAA_5555}};
    r4 = '0; r4[263:200] = 64'hDEADBEEF_CAFEF00D;

    // Reset state, with start and resp_valid asserted (reset wins)
    start = 1'b1; resp_valid = 1'b1; resp_flat = r1;
    tick(); tick();
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_match",   {31'd0, match},   32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_sig",     sig,              32'hFFFFFFFF);
    chk("rst_cnt",     {16'd0, resp_cnt}, 32'd0);
    start = 1'b0; resp_valid = 1'b0;
    rst_n = 1'b1;

    // resp_valid in IDLE is ignored
    give(r2);
    chk("idle_ign_sig", sig, 32'hFFFFFFFF);
    chk("idle_ign_cnt", {16'd0, resp_cnt}, 32'd0);

    // One all-zero response
    begin_run(16'd1, 32'h0);
    chk("z_busy", {31'd0, busy}, 32'd1);
    give('0);
    chk("z_done",  {31'd0, done}, 32'd1);
    chk("z_busy0", {31'd0, busy}, 32'd0);
    chk("z_sig",   sig, 32'hFB3EE249);
    chk("z_cnt",   {16'd0, resp_cnt}, 32'd1);
    chk("z_match", {31'd0, match}, 32'd0);

    // Only bit 0 set, golden matches
    begin_run(16'd1, 32'hFB3EE248);
    rb = '0; rb[0] = 1'b1;
    give(rb);
    chk("b0_sig",   sig, 32'hFB3EE248);
    chk("b0_match", {31'd0, match}, 32'd1);
    // resp_valid in DONE is ignored, match held
    give(r3);
    chk("done_ign_sig",   sig, 32'hFB3EE248);
    chk("done_ign_cnt",   {16'd0, resp_cnt}, 32'd1);
    chk("done_hold_match", {31'd0, match}, 32'd1);

    // Top chunk bit (bit 329 -> chunk 10 bit 9)
    begin_run(16'd1, 32'h0);
    rb = '0; rb[329] = 1'b1;
    give(rb);
    chk("b329_sig", sig, 32'hFB3EE049);
    // bits 0 and 32 cancel in the fold
    begin_run(16'd1, 32'h0);
    rb = '0; rb[0] = 1'b1; rb[32] = 1'b1;
    give(rb);
    chk("cancel_sig", sig, 32'hFB3EE249);

    // Two zero responses
    begin_run(16'd2, 32'hF2BCD925);
    give('0);
    chk("two_busy", {31'd0, busy}, 32'd1);
    give('0);
    chk("two_sig",   sig, 32'hF2BCD925);
    chk("two_cnt",   {16'd0, resp_cnt}, 32'd2);
    chk("two_match", {31'd0, match}, 32'd1);

    // Empty run: one RUN cycle, valid responses not absorbed
    resp_valid = 1'b1; resp_flat = r1;
    begin_run(16'd0, 32'hFFFFFFFF);
    chk("e_busy", {31'd0, busy}, 32'd1);
    tick();
    resp_valid = 1'b0;
    chk("e_done",  {31'd0, done}, 32'd1);
    chk("e_busy0", {31'd0, busy}, 32'd0);
    chk("e_sig",   sig, 32'hFFFFFFFF);
    chk("e_cnt",   {16'd0, resp_cnt}, 32'd0);
    chk("e_match", {31'd0, match}, 32'd1);

    // Idle watchdog (TIMEOUT=4)
    begin_run(16'd3, 32'hFB3EE249);
    give('0);
    tick(); tick(); tick();
    chk("to_busy3", {31'd0, busy}, 32'd1);
    chk("to_done3", {31'd0, done}, 32'd0);
    tick();
    chk("to_done",    {31'd0, done}, 32'd1);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_match",   {31'd0, match}, 32'd0);
    chk("to_cnt",     {16'd0, resp_cnt}, 32'd1);

    // Start pulsed mid-run is ignored
    begin_run(16'd4, 32'h0);
    chk("to_clr", {31'd0, timeout}, 32'd0);
    give(r1);
    start = 1'b1; cycles_target = 16'd1;
    give(r2);
    start = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_cnt",  {16'd0, resp_cnt}, 32'd2);
    tick();
    give(r3);
    give(r4);
    model = ref_step(ref_step(ref_step(ref_step(32'hFFFFFFFF, r1), r2), r3), r4);
    chk("mid_done", {31'd0, done}, 32'd1);
    chk("mid_sig",  sig, model);
    chk("mid_cnt4", {16'd0, resp_cnt}, 32'd4);

    // Reset mid-run aborts without DONE
    begin_run(16'd100, 32'h0);
    give(r1);
    give(r2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_sig",  sig, 32'hFFFFFFFF);
    chk("mr_cnt",  {16'd0, resp_cnt}, 32'd0);
    begin_run(16'd1, 32'hFB3EE249);
    give('0);
    chk("mr_re_sig",   sig, 32'hFB3EE249);
    chk("mr_re_match", {31'd0, match}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
